// File: rtl/tqvp_vga_sync_gen.sv
// XGA raster timing generator: free-running pixel/line counters with sync, blank,
// per-line retrace strobe and a sticky hblank/vblank interrupt flag.
module tqvp_vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 1024,
  parameter int unsigned H_NARROW  = 960,
  parameter int unsigned H_FRONT   = 24,
  parameter int unsigned H_SYNC    = 136,
  parameter int unsigned H_BACK    = 160,
  parameter int unsigned V_VISIBLE = 768,
  parameter int unsigned V_FRONT   = 3,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BACK    = 29,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cli,
  input  logic        enable_interrupt_on_hblank,
  input  logic        enable_interrupt_on_vblank,
  input  logic        narrow_960,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_WIDE_W     = 11'(H_VISIBLE);
  localparam logic [10:0] H_NARROW_W   = 11'(H_NARROW);
  localparam logic [10:0] H_SYNC_START = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_VIS_H      = 10'(V_VISIBLE);
  localparam logic [9:0]  V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] xCnt_q, xCnt_d;
  logic [9:0]  yCnt_q, yCnt_d;
  logic        irq_q, irq_d;
  logic [10:0] hWidth;
  logic        xWrap;
  logic        setH;
  logic        setV;

  // Visible width follows narrow_960 live, so the blank edge and hblank interrupt move with it.
  always_comb begin
    xWrap  = (xCnt_q == H_LAST);
    xCnt_d = xWrap ? 11'd0 : xCnt_q + 11'd1;
    yCnt_d = yCnt_q;
    if (xWrap) begin
      yCnt_d = (yCnt_q == V_LAST) ? 10'd0 : yCnt_q + 10'd1;
    end
    hWidth = narrow_960 ? H_NARROW_W : H_WIDE_W;
    setH   = enable_interrupt_on_hblank && (xCnt_q == hWidth) && (yCnt_q < V_VIS_H);
    setV   = enable_interrupt_on_vblank && (xCnt_q == 11'd0) && (yCnt_q == V_VIS_H);
    irq_d  = irq_q;
    if (setH || setV) begin
      irq_d = 1'b1;
    end else if (cli) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xCnt_q <= 11'd0;
      yCnt_q <= 10'd0;
      irq_q  <= 1'b0;
    end else begin
      xCnt_q <= xCnt_d;
      yCnt_q <= yCnt_d;
      irq_q  <= irq_d;
    end
  end

  // Decodes are unregistered; the downstream colour stage registers them for the pins.
  assign x         = xCnt_q;
  assign y         = yCnt_q;
  assign hsync     = ((xCnt_q >= H_SYNC_START) && (xCnt_q < H_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign vsync     = ((yCnt_q >= V_SYNC_START) && (yCnt_q < V_SYNC_END)) ? SYNC_POL : ~SYNC_POL;
  assign retrace   = (xCnt_q == H_SYNC_START);
  assign blank     = (xCnt_q >= hWidth) || (yCnt_q >= V_VIS_H);
  assign interrupt = irq_q;

endmodule
